// File: rtl/key_schedule_buffer.sv
// ============================================================================
// Module  : key_schedule_buffer
// Brief   : Sequences 44 AES-128 key-expansion words through an external
//           expansion stage and buffers the 11 resulting round keys for reads.
//           Optional macro KEYBUF_DECRYPT_ORDER_EN reverses the read order.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module key_schedule_buffer #(
  parameter int LAT = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [5:0]   exp_round,
  output logic [31:0]  exp_key0,
  input  logic [31:0]  exp_word,
  output logic         busy,
  output logic         ready,
  input  logic         rd_en,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key,
  output logic         rd_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           accept;
  logic [127:0]   key_reg;
  logic [5:0]     issue_cnt;
  logic [2:0]     drain_cnt;
  logic [LAT-1:0] pipe_vld;
  logic [5:0]     pipe_idx [LAT];
  logic [127:0]   store [11];
  logic [3:0]     rd_sel;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   if (issue_cnt == 6'd43) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == 3'(LAT - 1)) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      key_reg   <= '0;
      issue_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        key_reg   <= key_in;
        issue_cnt <= '0;
      end else if (state == ISSUE) begin
        issue_cnt <= (issue_cnt == 6'd43) ? 6'd0 : issue_cnt + 6'd1;
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
    end
  end

  assign busy      = (state == ISSUE) || (state == DRAIN);
  assign ready     = (state == DONE);
  assign exp_round = (state == ISSUE) ? issue_cnt : 6'd0;

  // Key words come from the captured copy so key_in is free to change after start.
  always_comb begin
    exp_key0 = '0;
    if (state == ISSUE && issue_cnt < 6'd4) begin
      case (issue_cnt[1:0])
        2'd0:    exp_key0 = key_reg[127:96];
        2'd1:    exp_key0 = key_reg[95:64];
        2'd2:    exp_key0 = key_reg[63:32];
        default: exp_key0 = key_reg[31:0];
      endcase
    end
  end

  // Issued index travels alongside the expansion stage latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe_vld <= '0;
      for (int k = 0; k < LAT; k++) pipe_idx[k] <= '0;
    end else begin
      pipe_vld[0] <= (state == ISSUE);
      pipe_idx[0] <= issue_cnt;
      for (int k = 1; k < LAT; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_idx[k] <= pipe_idx[k-1];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 11; i++) store[i] <= '0;
    end else if (pipe_vld[LAT-1]) begin
      for (int i = 0; i < 11; i++) begin
        for (int j = 0; j < 4; j++) begin
          if (pipe_idx[LAT-1] == 6'(4 * i + j)) store[i][127-32*j -: 32] <= exp_word;
        end
      end
    end
  end

`ifdef KEYBUF_DECRYPT_ORDER_EN
  assign rd_sel = 4'd10 - rd_idx;
`else
  assign rd_sel = rd_idx;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_key   <= '0;
    end else begin
      rd_valid <= rd_en && ready;
      if (rd_en && ready) rd_key <= (rd_idx > 4'd10) ? 128'd0 : store[rd_sel];
    end
  end

endmodule

`default_nettype wire
